// File: rtl/stepper_pkg.sv
// Shared defaults and width helpers for the pattern stepper slice.
package stepper_pkg;

    localparam int          DEF_N          = 4;
    localparam logic [15:0] DEF_PATTERN    = 16'b1011;
    localparam int          DEF_DEB_CYCLES = 1_000_000;
    localparam int          DEF_CNT_W      = 8;

    // Width needed to hold a fill count of 0..n inclusive.
    function automatic int fill_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Purpose: synchronize and debounce an active-low pushbutton, emit one pulse per press.
// Latency: 2 sync clocks + DEB_CYCLES stable clocks, then step is registered one more clock.
// Backpressure: none; free-running on the raw button, step is a single-cycle strobe.
module debounce_pulse
    import stepper_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pb,
    output logic level,
    output logic step
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          settle;

    // The DEB_CYCLES-th consecutive clock on which the synced button disagrees.
    assign settle = (sync2 != level) && (cnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            step  <= 1'b0;
        end else begin
            sync1 <= pb;
            sync2 <= sync1;
            step  <= settle && !sync2;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_stepper.sv
// Purpose: step-driven N-bit sequence detector with match/no-match flags and saturating match count.
// Latency: t/f/match_count/hist update on the clock edge that samples the step pulse.
// Backpressure: none; each debounced press is one step, inputs are only sampled on that cycle.
module pattern_stepper
    import stepper_pkg::*;
#(
    parameter int             N          = DEF_N,
    parameter logic [N-1:0]   PATTERN    = DEF_PATTERN[N-1:0],
    parameter int             DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int             CNT_W      = DEF_CNT_W
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             pb,
    input  logic             i,
    input  logic             overlap,
    output logic             t,
    output logic             f,
    output logic [CNT_W-1:0] match_count,
    output logic [N-1:0]     hist
);

    localparam int FW = fill_w(N);

    logic          deb_level;
    logic          deb_step;
    logic          step;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_nxt;
    logic [N-1:0]  hist_nxt;
    logic          full_nxt;
    logic          match;

    debounce_pulse #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk   (CLOCK_50),
        .reset (reset),
        .pb    (pb),
        .level (deb_level),
        .step  (deb_step)
    );

    // The pulse is only honoured while the debounced button reads pressed.
    assign step = deb_step && !deb_level;

    always_comb begin
        hist_nxt = {hist[N-2:0], i};
        fill_nxt = (fill == FW'(N)) ? fill : fill + FW'(1);
        full_nxt = (fill_nxt == FW'(N));
        match    = full_nxt && (hist_nxt == PATTERN);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            t           <= 1'b0;
            f           <= 1'b0;
            match_count <= '0;
            hist        <= '0;
            fill        <= '0;
        end else if (step) begin
            hist <= hist_nxt;
            t    <= match;
            f    <= full_nxt && !match;
            fill <= (match && !overlap) ? '0 : fill_nxt;
            if (match && (match_count != {CNT_W{1'b1}})) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pattern_stepper.sv
// Bench for pattern_stepper: table-driven press sequences with a scoreboard queue, plus reset/glitch corners.
module tb_pattern_stepper;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pb = 1'b1;
    logic       i = 1'b0;
    logic       overlap = 1'b0;
    logic       t, f, t2, f2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [3:0] hist, hist2;

    always #5 clk = ~clk;

    pattern_stepper #(
        .N(4), .PATTERN(4'b1011), .DEB_CYCLES(4), .CNT_W(8)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .pb(pb), .i(i), .overlap(overlap),
        .t(t), .f(f), .match_count(cnt), .hist(hist)
    );

    pattern_stepper #(
        .N(4), .PATTERN(4'b1011), .DEB_CYCLES(4), .CNT_W(2)
    ) dut_sat (
        .CLOCK_50(clk), .reset(reset), .pb(pb), .i(i), .overlap(overlap),
        .t(t2), .f(f2), .match_count(cnt2), .hist(hist2)
    );

    typedef struct {
        logic       i;
        logic       ov;
        logic       t;
        logic       f;
        logic [7:0] cnt;
        logic [1:0] sat;
        logic [3:0] hist;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t tbl_c[$];
    vec_t sb[$];

    int checks   = 0;
    int failures = 0;
    int step_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (dut.u_deb.step) step_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    function automatic vec_t mk(input logic iv, input logic ov, input logic et, input logic ef,
                                input logic [7:0] ec, input logic [1:0] es, input logic [3:0] eh);
        vec_t v;
        v.i = iv; v.ov = ov; v.t = et; v.f = ef; v.cnt = ec; v.sat = es; v.hist = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic press(input vec_t v, input string tag);
        int   s0;
        logic seen;
        vec_t e;
        @(negedge clk);
        i       = v.i;
        overlap = v.ov;
        pb      = 1'b0;
        s0      = step_cnt;
        seen    = 1'b0;
        sb.push_back(v);
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (dut.u_deb.step) seen = 1'b1;
        end
        chk({tag, " step_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, " t"}, 32'(t), 32'(e.t));
        chk({tag, " f"}, 32'(f), 32'(e.f));
        chk({tag, " count"}, 32'(cnt), 32'(e.cnt));
        chk({tag, " hist"}, 32'(hist), 32'(e.hist));
        chk({tag, " sat_count"}, 32'(cnt2), 32'(e.sat));
        chk({tag, " t_and_f"}, 32'(t & f), 32'd0);
        // Inputs toggled between steps must not be picked up.
        i       = ~v.i;
        overlap = ~v.ov;
        repeat (10) @(negedge clk);
        pb = 1'b1;
        repeat (12) @(negedge clk);
        chk({tag, " one_step_per_press"}, 32'(step_cnt), 32'(s0 + 1));
        chk({tag, " t_held"}, 32'(t), 32'(e.t));
        chk({tag, " f_held"}, 32'(f), 32'(e.f));
    endtask

    initial begin
        int         s0;
        logic [3:0] h0;

        // Overlapping run, long enough to saturate the 2-bit counter.
        tbl_a.push_back(mk(1, 1, 0, 0, 0, 0, 4'b0001));
        tbl_a.push_back(mk(0, 1, 0, 0, 0, 0, 4'b0010));
        tbl_a.push_back(mk(1, 1, 0, 0, 0, 0, 4'b0101));
        tbl_a.push_back(mk(1, 1, 1, 0, 1, 1, 4'b1011));
        tbl_a.push_back(mk(0, 1, 0, 1, 1, 1, 4'b0110));
        tbl_a.push_back(mk(1, 1, 0, 1, 1, 1, 4'b1101));
        tbl_a.push_back(mk(1, 1, 1, 0, 2, 2, 4'b1011));
        tbl_a.push_back(mk(0, 1, 0, 1, 2, 2, 4'b0110));
        tbl_a.push_back(mk(1, 1, 0, 1, 2, 2, 4'b1101));
        tbl_a.push_back(mk(1, 1, 1, 0, 3, 3, 4'b1011));
        tbl_a.push_back(mk(0, 1, 0, 1, 3, 3, 4'b0110));
        tbl_a.push_back(mk(1, 1, 0, 1, 3, 3, 4'b1101));
        tbl_a.push_back(mk(1, 1, 1, 0, 4, 3, 4'b1011));
        tbl_a.push_back(mk(0, 1, 0, 1, 4, 3, 4'b0110));
        tbl_a.push_back(mk(1, 1, 0, 1, 4, 3, 4'b1101));
        tbl_a.push_back(mk(1, 1, 1, 0, 5, 3, 4'b1011));

        // Non-overlapping run: fill restarts after the first match.
        tbl_b.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0001));
        tbl_b.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0010));
        tbl_b.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0101));
        tbl_b.push_back(mk(1, 0, 1, 0, 1, 1, 4'b1011));
        tbl_b.push_back(mk(0, 0, 0, 0, 1, 1, 4'b0110));
        tbl_b.push_back(mk(1, 0, 0, 0, 1, 1, 4'b1101));
        tbl_b.push_back(mk(1, 0, 0, 0, 1, 1, 4'b1011));
        tbl_b.push_back(mk(0, 0, 0, 1, 1, 1, 4'b0110));
        tbl_b.push_back(mk(1, 0, 0, 1, 1, 1, 4'b1101));

        // After a mid-press reset: history must rebuild from scratch.
        tbl_c.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0001));
        tbl_c.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0010));
        tbl_c.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0101));

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset t", 32'(t), 32'd0);
        chk("reset f", 32'(f), 32'd0);
        chk("reset count", 32'(cnt), 32'd0);
        chk("reset hist", 32'(hist), 32'd0);
        chk("reset sat_count", 32'(cnt2), 32'd0);
        chk("reset level", 32'(dut.u_deb.level), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        foreach (tbl_a[k]) press(tbl_a[k], $sformatf("ovl step%0d", k + 1));

        // Three-clock low glitch is shorter than the debounce window.
        h0 = hist;
        s0 = step_cnt;
        @(negedge clk);
        pb = 1'b0;
        repeat (3) @(negedge clk);
        pb = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch no_step", 32'(step_cnt), 32'(s0));
        chk("glitch hist", 32'(hist), 32'(h0));

        do_reset();
        repeat (3) @(negedge clk);
        foreach (tbl_b[k]) press(tbl_b[k], $sformatf("novl step%0d", k + 1));

        // Reset lands while a press is still being debounced.
        @(negedge clk);
        pb = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        pb = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        s0 = step_cnt;
        chk("midrst t", 32'(t), 32'd0);
        chk("midrst f", 32'(f), 32'd0);
        chk("midrst count", 32'(cnt), 32'd0);
        chk("midrst hist", 32'(hist), 32'd0);
        chk("midrst sat_count", 32'(cnt2), 32'd0);
        repeat (20) @(negedge clk);
        chk("midrst no_step", 32'(step_cnt), 32'(s0));

        foreach (tbl_c[k]) press(tbl_c[k], $sformatf("postrst step%0d", k + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_stepper.md
PATTERN_STEPPER -- requirements
Module: pattern_stepper

Interface
REQ-001 SHALL have parameter N, default 4, meaning pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter PATTERN, default 4'b1011, meaning target sequence of N bits, MSB is the oldest bit.
REQ-003 SHALL have parameter DEB_CYCLES, default 1_000_000, meaning required raw-button stable time in clocks (20 ms at 50 MHz).
REQ-004 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-005 SHALL have port CLOCK_50, input, 1 bit, meaning the single clock.
REQ-006 SHALL have port reset, input, 1 bit, meaning synchronous, active-low reset.
REQ-007 SHALL have port pb, input, 1 bit, meaning raw asynchronous pushbutton, active-low (pressed = 0).
REQ-008 SHALL have port i, input, 1 bit, meaning data bit sampled on each step.
REQ-009 SHALL have port overlap, input, 1 bit, meaning 1 = overlapping detection, 0 = restart after match.
REQ-010 SHALL have port t, output, 1 bit, meaning last step completed a match.
REQ-011 SHALL have port f, output, 1 bit, meaning last step evaluated with no match.
REQ-012 SHALL have port match_count, output, CNT_W bits, meaning total matches, saturating.
REQ-013 SHALL have port hist, output, N bits, meaning current shift history (for display).

Function
REQ-014 SHALL pass pb through a 2-flop synchronizer before any use.
REQ-015 SHALL update the debounced level only after the synchronized pb differs from it for DEB_CYCLES consecutive clocks; any reversal before that restarts the count.
REQ-016 SHALL generate a one-clock step pulse on each debounced 1->0 transition; a held button yields exactly one step.
REQ-017 SHALL, on step, shift i into hist LSB and increment valid count fill, saturating at N.
REQ-018 SHALL evaluate using the post-shift history; match = (fill == N) and (hist == PATTERN).
REQ-019 SHALL update t and f exactly 1 clock after the step pulse; t = match, f = (fill == N) and not match; both held until the next step.
REQ-020 SHALL keep t = f = 0 while fill < N (insufficient history).
REQ-021 SHALL increment match_count on match, saturating at 2^CNT_W-1 (no wrap).
REQ-022 SHALL, when overlap = 0 and match, clear fill to 0 (hist retained); next decision requires N fresh steps.
REQ-023 SHALL sample overlap and i only on the step cycle; changes between steps have no effect.
REQ-024 SHALL never assert t and f together.

Reset
REQ-025 SHALL, when reset = 0 at a clock edge, set t = 0, f = 0, match_count = 0, hist = 0, fill = 0, the debounced level = 1 (released), the debounce counter = 0, and the synchronizer flops = 1.
REQ-026 SHALL give reset priority over a coincident step; a press in progress during reset produces no step.

Structure
REQ-027 SHALL place the default parameter values and the fill-width function (clog2(N+1)) in shared package stepper_pkg.
REQ-028 SHALL implement synchronizer, debounce and edge-pulse logic as sub-module debounce_pulse (ports clk, reset, pb, level, step).

Verification
REQ-029 SHALL cover: N=4, PATTERN=1011, DEB_CYCLES=4; clean presses with i=1,0,1,1 -> t=1, f=0 one clock after the 4th step; match_count=1.
REQ-030 SHALL cover: a pb low glitch of 3 clocks -> no step, and hist unchanged.
REQ-031 SHALL cover: overlap=1, inputs 1,0,1,1,0,1,1 -> t on steps 4 and 7; match_count=2.
REQ-032 SHALL cover: overlap=0 with the same inputs -> t on step 4 only, step 7 gives t = f = 0; match_count=1.
REQ-033 SHALL cover: CNT_W=2 with 5 matches -> match_count saturates at 3.
REQ-034 SHALL cover: reset asserted mid-debounce and after 2 steps -> all outputs 0; the next 3 steps give t = f = 0.
